// File: rtl/reg_rmw_pkg.sv
// Shared types for the register-file read-modify-write master.
// Holds ALU op encoding, FSM states and default widths.
package reg_rmw_pkg;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 5;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_EXEC  = 2'b10,
    ST_WRITE = 2'b11
  } state_e;

endpackage

// File: rtl/reg_rmw_master_alu.sv
// Combinational 2-bit-op ALU used by reg_rmw_master.
// ADD/SUB wrap modulo 2^DW.
module rmw_alu
  import reg_rmw_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  op_e           i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_res
);

  always_comb begin
    o_res = '0;
    unique case (i_op)
      OP_ADD: o_res = i_a + i_b;
      OP_SUB: o_res = i_a - i_b;
      OP_AND: o_res = i_a & i_b;
      OP_OR:  o_res = i_a | i_b;
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/reg_rmw_master.sv
// Read-modify-write initiator for a 2R/1W register file.
// Option RMW_ZERO_REG_EN: treat address 0 as hardwired zero.
module reg_rmw_master
  import reg_rmw_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [AW-1:0] cmd_rd,
  output logic [AW-1:0] A1,
  output logic [AW-1:0] A2,
  input  logic [DW-1:0] RD1,
  input  logic [DW-1:0] RD2,
  output logic [AW-1:0] A3,
  output logic [DW-1:0] WD3,
  output logic          rw,
  output logic          done,
  output logic [DW-1:0] res_data
);

  state_e        r_state;
  state_e        w_next;
  op_e           r_op;
  logic [AW-1:0] r_rs1;
  logic [AW-1:0] r_rs2;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_a3;
  logic [DW-1:0] r_opa;
  logic [DW-1:0] r_opb;
  logic [DW-1:0] r_res;
  logic [DW-1:0] r_res_data;
  logic          r_done;
  logic [DW-1:0] w_res;
  logic [DW-1:0] w_opa;
  logic [DW-1:0] w_opb;
  logic          w_wr_ok;

`ifdef RMW_ZERO_REG_EN
  assign w_opa   = (r_rs1 == '0) ? '0 : RD1;
  assign w_opb   = (r_rs2 == '0) ? '0 : RD2;
  assign w_wr_ok = (r_a3 != '0);
`else
  assign w_opa   = RD1;
  assign w_opb   = RD2;
  assign w_wr_ok = 1'b1;
`endif

  rmw_alu #(.DW(DW)) u_alu (
    .i_op  (r_op),
    .i_a   (r_opa),
    .i_b   (r_opb),
    .o_res (w_res)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    rw        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = ST_READ;
      end
      ST_READ: w_next = ST_EXEC;
      ST_EXEC: w_next = ST_WRITE;
      ST_WRITE: begin
        rw     = w_wr_ok;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= OP_ADD;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_a3       <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_res      <= '0;
      r_res_data <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == ST_WRITE);
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op  <= op_e'(cmd_op);
            r_rs1 <= cmd_rs1;
            r_rs2 <= cmd_rs2;
            r_rd  <= cmd_rd;
          end
        end
        ST_READ: begin
          r_opa <= w_opa;
          r_opb <= w_opb;
        end
        // A3 gets its own copy so it holds after the next accept
        ST_EXEC: begin
          r_res <= w_res;
          r_a3  <= r_rd;
        end
        ST_WRITE: r_res_data <= r_res;
        default: ;
      endcase
    end
  end

  assign A1       = r_rs1;
  assign A2       = r_rs2;
  assign A3       = r_a3;
  assign WD3      = r_res;
  assign done     = r_done;
  assign res_data = r_res_data;

endmodule

// File: doc/reg_rmw_master.md
Name: reg_rmw_master

Overview:
- Initiator side of the 2-read/1-write register-file interface (A1/A2 read addresses, RD1/RD2 read data, A3/WD3/rw write port).
- Accepts one read-modify-write command at a time: reads rs1/rs2, applies a 2-bit ALU op, writes the result to rd.
- Sits between a command source (datapath/test controller) and the register file; returns a one-cycle done pulse with the written value.

Parameters:
- DW, 32, data width (RD1/RD2/WD3/res_data)
- AW, 5, register address width (A1/A2/A3/cmd_rs1/cmd_rs2/cmd_rd)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR
- cmd_rs1  in  AW  source 1 address
- cmd_rs2  in  AW  source 2 address
- cmd_rd  in  AW  destination address
- A1  out  AW  regfile read address 1
- A2  out  AW  regfile read address 2
- RD1  in  DW  regfile read data 1 (combinational from A1)
- RD2  in  DW  regfile read data 2 (combinational from A2)
- A3  out  AW  regfile write address
- WD3  out  DW  regfile write data
- rw  out  1  regfile write enable, 1 = write on posedge clk
- done  out  1  one-cycle pulse, write committed
- res_data  out  DW  value written; held until next done

Behaviour:
- Reset (rst=1 at posedge): state IDLE. cmd_ready=1. A1=A2=A3=0, WD3=0, rw=0, done=0, res_data=0. Internal op/rd/operand registers cleared.
- Reset is honoured mid-operation from any state. An in-flight command is dropped. No write is issued in the cycle after rst.
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready at posedge: latch op, rs1, rs2, rd; go to READ.
- READ:
  - cmd_ready=0.
  - A1=rs1, A2=rs2 (registered, valid for the whole cycle).
  - At posedge: capture RD1 to opa and RD2 to opb; go to EXEC.
- EXEC:
  - At posedge: compute res = opa op opb, width DW.
  - ADD/SUB wrap modulo 2^DW. No carry/overflow output.
  - Go to WRITE.
- WRITE:
  - A3=rd, WD3=res, rw=1 for exactly one cycle; regfile commits at the posedge ending this cycle.
  - Same posedge: done=1 for the following cycle, res_data=res, return to IDLE.
- Timing:
  - Accept-to-write-commit latency is 3 cycles.
  - done is asserted in the cycle after commit, which is also the first IDLE cycle.
  - Throughput: one command per 4 cycles. cmd_ready is low in READ/EXEC/WRITE.
- rw=0 in every state except WRITE. A3/WD3 hold their last values outside WRITE.
- rd equal to rs1 or rs2 is allowed: the read precedes the write, so the old value is used.
- Back-to-back dependent commands see the prior result, because the write commits before the next READ.
- cmd_valid while cmd_ready=0 is ignored. The source must hold the command until accepted.

Optional Feature:
- Macro RMW_ZERO_REG_EN.
- Defined:
  - Address 0 is hardwired zero: opa/opb forced to 0 when rs1/rs2==0.
  - A command with rd==0 keeps rw=0 in WRITE.
  - done still pulses, with res_data = computed result.
- Undefined: address 0 is an ordinary register; reads and writes pass through unchanged.

Decomposition:
- Package reg_rmw_pkg: op encoding enum (OP_ADD/OP_SUB/OP_AND/OP_OR), FSM state enum, default DW/AW constants.
- One sub-module is natural: rmw_alu, purely combinational 2-bit op, DW-wide. Instantiated once, fed from opa/opb.

Test Plan (bench pairs the block with a behavioural 32x32 register file):
- Reset mid-READ: accept cmd, assert rst in READ -> rw never 1, done=0, cmd_ready=1 next cycle, all outputs 0.
- Preload r1=5, r2=3; ADD rs1=1 rs2=2 rd=4 -> rw=1 with A3=4, WD3=8 exactly 3 cycles after accept; done next cycle with res_data=8; r4 reads 8.
- SUB r2-r1 with r1=5, r2=3 into rd=6 -> WD3=0xFFFFFFFE (wrap). AND/OR 0xF0F0F0F0 with 0x0FF00FF0 -> 0x00F000F0 and 0xFFF0FFF0.
- Dependent back-to-back: ADD rd=7=r1+r2, then OR rs1=7 rs2=7 rd=8, cmd_valid held high -> second accept exactly 4 cycles after first; r8=8.
- In-place: r3=0x10, ADD rs1=3 rs2=3 rd=3 -> WD3=0x20, old value used.
- RMW_ZERO_REG_EN defined: preload r0=0x55 via bench backdoor; ADD rs1=0 rs2=1 (r1=5) rd=0 -> rw stays 0, done=1, res_data=5. Undefined: res_data=0x5A and r0 written.
